resource_pool_arbiter: RTL
==========================

# resource_pool_arbiter

Shares a pool of NUM_RES identical execution resources (ALU units or memory ports) among NUM_REQ single-instruction controllers. Each controller raises a request tagged with its issue ID, and the arbiter grants a free unit to the oldest pending requester. The unit stays locked to that requester until the requester pulses release or drops its request. One arbiter instance sits between the SIC array and each resource pool, and drives the per-SIC `grant` inputs.

## Interface
- NUM_REQ, 4: number of requesters (SICs).
- NUM_RES, 1: number of units in the pool; 1 ≤ NUM_RES ≤ NUM_REQ.
- ID_WIDTH, 4: issue-ID width.
- UW = max(1, $clog2(NUM_RES)): unit-index width (derived, local).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester lock request, level, held while the lock is wanted.
- req_issue_id  in  NUM_REQ×ID_WIDTH  issue ID of each requester; sampled only while req is high.
- release_lock  in  NUM_REQ  single-cycle release pulse per requester.
- grant  out  NUM_REQ  registered; high while the requester owns a unit.
- grant_unit  out  NUM_REQ×UW  registered; index of the owned unit, valid while grant is high, 0 otherwise.
- free_count  out  $clog2(NUM_RES+1)  registered; number of unowned units.

## Operation
- State per unit: owned flag plus owner index. State per requester: held flag, which equals grant.
- Age rule:
  - Requester a is older than b when (req_issue_id[a] − req_issue_id[b]) mod 2^ID_WIDTH, read as signed ID_WIDTH, is negative.
  - Equal IDs resolve to the lower requester index.
  - Correct only while live IDs span < 2^(ID_WIDTH−1); the issue controller guarantees this.
- Candidates each cycle: requesters with req=1, grant=0 and release_lock=0.
- Allocation:
  - At most one new grant per cycle.
  - If at least one unit was free at the start of the cycle and a candidate exists, the oldest candidate receives the lowest-indexed free unit.
- Release: a holder frees its unit on either condition:
  - release_lock=1, or
  - req=0 (covers mispredict abort, where the SIC drops req one cycle before its release pulse).
- Ignored inputs:
  - release_lock from a non-holder.
  - A second release from the same requester.
- A unit freed in cycle t is not reallocatable in cycle t; it becomes a candidate target in cycle t+1. There is no same-edge handoff.
- Holders keep their unit regardless of age. There is no preemption.
- free_count = NUM_RES − number of owned units, updated at the same edge as grant.

## Timing
- Reset (async assert, sync release):
  - grant=0, grant_unit=0, free_count=NUM_RES.
  - All units unowned.
  - Reset in mid-operation drops every lock immediately.
- Grant latency:
  - req rising before edge t with a free unit and the requester oldest → grant=1 after edge t, so it is visible in cycle t+1.
  - Minimum request-to-grant is 1 cycle.
- Release latency:
  - release_lock (or req low) sampled at edge t → grant=0 and the unit is free after edge t.
  - A waiting requester can be granted at edge t+1 at the earliest.
- Simultaneous release by A and new request by B with a full pool: B is not granted until the edge after A's release.
- Multiple simultaneous releases are all processed in the same edge. free_count may rise by more than 1.
- req held high after grant has no further effect. grant stays high until release.
- A requester whose req and release_lock are both 1 while not holding is not a candidate that cycle.

## Test plan
- Basic lock:
  - Stimulus: NUM_RES=1; SIC0 req, id=3.
  - Required: grant[0]=1 one cycle later, grant_unit[0]=0, free_count=0.
  - Stimulus: release_lock[0] pulse.
  - Required: grant[0]=0 next cycle, free_count=1.
- Age priority with wrap:
  - Stimulus: ID_WIDTH=4, NUM_RES=1; SIC1 id=14 and SIC2 id=1 request together.
  - Required: SIC1 granted first (14 older than 1 across wrap); after SIC1 releases at edge t, SIC2 is granted at edge t+1.
- Multi-unit:
  - Stimulus: NUM_RES=2; SIC0 id=5, SIC1 id=6, SIC2 id=7 all request.
  - Required: grant order SIC0 (unit 0), then SIC1 (unit 1) on consecutive cycles; SIC2 waits; free_count goes 2→1→0.
- Abort release:
  - Stimulus: a holder drops req without a pulse, then pulses release_lock the next cycle.
  - Required: unit freed on the req drop; the later pulse is ignored; free_count never exceeds NUM_RES.
- No same-edge handoff:
  - Stimulus: pool full; SIC0 releases in cycle t while SIC3 is requesting.
  - Required: grant[3] rises after edge t+1, not edge t.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while two units are held.
  - Required: grant=0 and free_count=NUM_RES asynchronously; after reset deasserts, pending requests re-arbitrate by age.

Source files
------------

// File: rtl/resource_pool_arbiter_if.sv
// rtl/resource_pool_arbiter_if.sv - request/grant bundle between the SIC array and one resource pool arbiter
interface resource_pool_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_RES  = 1,
    parameter int ID_WIDTH = 4
) ();
    localparam int UW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
    localparam int CW = $clog2(NUM_RES + 1);

    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0][ID_WIDTH-1:0] req_issue_id;
    logic [NUM_REQ-1:0]               release_lock;
    logic [NUM_REQ-1:0]               grant;
    logic [NUM_REQ-1:0][UW-1:0]       grant_unit;
    logic [CW-1:0]                    free_count;

    // SIC array side: raises requests, observes grants
    modport master (
        output req,
        output req_issue_id,
        output release_lock,
        input  grant,
        input  grant_unit,
        input  free_count
    );

    // Arbiter side
    modport slave (
        input  req,
        input  req_issue_id,
        input  release_lock,
        output grant,
        output grant_unit,
        output free_count
    );
endinterface

// File: rtl/resource_pool_arbiter.sv
// rtl/resource_pool_arbiter.sv - oldest-first lock arbiter sharing NUM_RES units among NUM_REQ SICs
module resource_pool_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_RES  = 1,
    parameter int ID_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    resource_pool_arbiter_if.slave bus
);
    localparam int UW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
    localparam int CW = $clog2(NUM_RES + 1);
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester a is older than b when (a - b) wraps to a negative value,
    // so ordering stays correct across issue-ID rollover.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a,
                                      input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    // Registered state: held flag and owned unit per requester, owned flag per unit.
    // The owner of a unit is implied by whichever holder carries its index.
    logic [NUM_REQ-1:0]         held_q;
    logic [NUM_REQ-1:0][UW-1:0] unit_q;
    logic [NUM_RES-1:0]         owned_q;
    logic [CW-1:0]              free_q;

    logic [NUM_REQ-1:0]         held_d;
    logic [NUM_REQ-1:0][UW-1:0] unit_d;
    logic [NUM_RES-1:0]         owned_d;
    logic [CW-1:0]              free_d;

    logic [NUM_REQ-1:0]         release_v;
    logic [NUM_REQ-1:0]         cand;
    logic                       win_found;
    logic [RW-1:0]              win_idx;
    logic [ID_WIDTH-1:0]        win_id;
    logic                       free_found;
    logic [UW-1:0]              free_idx;
    logic                       do_grant;
    logic [CW-1:0]              owned_cnt;

    // Classify each requester: holders that let go this cycle, and fresh candidates.
    // A requester pulsing release while not holding is neither.
    always_comb begin
        release_v = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            release_v[i] = held_q[i] & (bus.release_lock[i] | ~bus.req[i]);
            cand[i]      = bus.req[i] & ~held_q[i] & ~bus.release_lock[i];
        end
    end

    // Pick the oldest candidate; ascending scan with strict compare keeps
    // the lower index on equal IDs.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand[i] && (!win_found || is_older(bus.req_issue_id[i], win_id))) begin
                win_found = 1'b1;
                win_idx   = RW'(i);
                win_id    = bus.req_issue_id[i];
            end
        end
    end

    // Lowest-indexed unit free at the start of the cycle; units released
    // this cycle are deliberately not visible here.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int u = NUM_RES - 1; u >= 0; u--) begin
            if (!owned_q[u]) begin
                free_found = 1'b1;
                free_idx   = UW'(u);
            end
        end
    end

    // Next state: apply every release, then at most one new grant.
    always_comb begin
        held_d    = held_q & ~release_v;
        unit_d    = unit_q;
        owned_d   = owned_q;
        do_grant  = win_found & free_found;
        owned_cnt = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (release_v[i]) begin
                for (int u = 0; u < NUM_RES; u++) begin
                    if (unit_q[i] == UW'(u)) begin
                        owned_d[u] = 1'b0;
                    end
                end
                unit_d[i] = '0;
            end
        end

        if (do_grant) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win_idx == RW'(i)) begin
                    held_d[i] = 1'b1;
                    unit_d[i] = free_idx;
                end
            end
            for (int u = 0; u < NUM_RES; u++) begin
                if (free_idx == UW'(u)) begin
                    owned_d[u] = 1'b1;
                end
            end
        end

        for (int u = 0; u < NUM_RES; u++) begin
            owned_cnt = owned_cnt + CW'(owned_d[u]);
        end
        free_d = CW'(NUM_RES) - owned_cnt;
    end

    // State register; reset drops every lock immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q  <= '0;
            unit_q  <= '0;
            owned_q <= '0;
            free_q  <= CW'(NUM_RES);
        end else begin
            held_q  <= held_d;
            unit_q  <= unit_d;
            owned_q <= owned_d;
            free_q  <= free_d;
        end
    end

    assign bus.grant      = held_q;
    assign bus.grant_unit = unit_q;
    assign bus.free_count = free_q;

endmodule
